gcd_requester: RTL
==================

GCD_REQUESTER -- requirements
Module: gcd_requester

Interface
REQ-001 Parameter WIDTH, default 16: operand/result bit width.
REQ-002 Parameter TIMEOUT, default 255: maximum wait cycles per job (used only under GCD_TIMEOUT_EN).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 in_valid  input  1  operand pair offered.
REQ-006 in_ready  output  1  requester accepts a pair this cycle.
REQ-007 in_a, in_b  input  WIDTH  operands.
REQ-008 go  output  1  start pulse to the GCD controller.
REQ-009 a_out, b_out  output  WIDTH  registered operands driven to the GCD datapath load inputs.
REQ-010 done  input  1  controller idle/finished flag.
REQ-011 output_en  input  1  controller result-valid strobe.
REQ-012 gcd_in  input  WIDTH  datapath result.
REQ-013 res_valid  output  1  result available.
REQ-014 res_ready  input  1  consumer accepts result.
REQ-015 res_gcd  output  WIDTH  captured result.
REQ-016 res_err  output  1  job aborted (timeout); valid with res_valid.
REQ-017 busy  output  1  high in any state except IDLE.

Function
REQ-018 States: IDLE, START, WAIT_ACK, WAIT_DONE, HOLD.
REQ-019 in_ready SHALL equal (state==IDLE), combinationally.
REQ-020 IDLE: on in_valid&in_ready, capture in_a/in_b into a_out/b_out; if both operands are non-zero, go to START.
REQ-021 Zero-operand bypass: if in_a==0 or in_b==0, the block SHALL NOT assert go; it SHALL load res_gcd=in_a|in_b, res_err=0 and enter HOLD (res_valid high the cycle after acceptance).
REQ-022 START: go=1 for exactly one cycle; then WAIT_ACK. go SHALL be 0 in every other state.
REQ-023 WAIT_ACK: remain until done==0, then WAIT_DONE.
REQ-024 WAIT_DONE: when done==1 and output_en==1, capture gcd_in into res_gcd, res_err=0, enter HOLD.
REQ-025 HOLD: res_valid=1, res_gcd/res_err stable; on res_ready, go to IDLE the next cycle.
REQ-026 a_out/b_out SHALL stay constant from acceptance until return to IDLE.
REQ-027 Latency from acceptance edge to go high: 1 cycle; from output_en sample to res_valid: 1 cycle.
REQ-028 New input is never accepted while a result is pending (HOLD), so acceptance and result handoff never coincide.

Reset
REQ-029 While rst is high: state=IDLE, go=0, res_valid=0, res_err=0, res_gcd=0, a_out=b_out=0, busy=0; timer cleared.
REQ-030 Reset asserted mid-job SHALL abandon the job with no result output; in_ready=1 on the first cycle after release.

Configuration
REQ-031 Macro GCD_TIMEOUT_EN defined: a counter runs in WAIT_ACK/WAIT_DONE, cleared on entry to START; when it reaches TIMEOUT with no completion, the block SHALL enter HOLD with res_gcd=0, res_err=1.
REQ-032 Macro undefined: no counter, res_err tied 0, and the block waits indefinitely in WAIT_ACK/WAIT_DONE.

Structure
REQ-033 Shared package gcd_pkg SHALL hold the state encoding constants and the default WIDTH.
REQ-034 Timeout counter SHALL be sub-module gcd_req_timer, instantiated only under GCD_TIMEOUT_EN.

Verification
REQ-035 Bench with real controller and datapath; in=(48,18), res_ready=1 -> one go pulse, res_gcd=6, res_err=0.
REQ-036 in=(0,35) -> go never asserted, res_valid one cycle after acceptance, res_gcd=35; in=(0,0) -> res_gcd=0.
REQ-037 in=(21,14), res_ready held low 10 cycles -> res_valid, res_gcd=7 stable, in_ready=0 throughout; release -> IDLE next cycle.
REQ-038 GCD_TIMEOUT_EN, TIMEOUT=20, model holds done=1 and never asserts output_en -> res_valid with res_err=1, res_gcd=0 after 20 wait cycles.
REQ-039 rst pulsed during WAIT_DONE -> go=0, res_valid=0, busy=0 immediately; the next pair (9,6) yields res_gcd=3.
REQ-040 Back-to-back pairs (12,8) then (17,5) with in_valid held -> results 4 then 1, each accepted only after the previous result's handoff.

Source files
------------

// File: rtl/gcd_pkg.sv
// Shared definitions for the GCD requester: state encoding and default width.
// Used by gcd_requester and gcd_req_timer.
package gcd_pkg;

   localparam int GCD_WIDTH = 16;

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_START     = 3'd1,
      S_WAIT_ACK  = 3'd2,
      S_WAIT_DONE = 3'd3,
      S_HOLD      = 3'd4
   } state_e;

   function automatic logic any_zero(input logic [GCD_WIDTH-1:0] a,
                                     input logic [GCD_WIDTH-1:0] b);
      return (a == '0) || (b == '0);
   endfunction

endpackage

// File: rtl/gcd_req_timer.sv
// Per-job wait counter for the GCD requester; expired_o flags the last
// allowed wait cycle. Only instantiated when GCD_TIMEOUT_EN is defined.
module gcd_req_timer
   import gcd_pkg::*;
#(
   parameter int TIMEOUT = 255
) (
   input  logic clk,
   input  logic rst,
   input  logic clr_i,
   input  logic en_i,
   output logic expired_o
);

   localparam int CW = $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

   logic [CW-1:0] cnt_q;

   assign expired_o = en_i && (cnt_q == LAST);

   // Count wait cycles; restart on each new job, hold once expired.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else if (clr_i) begin
         cnt_q <= '0;
      end else if (en_i && !expired_o) begin
         cnt_q <= cnt_q + 1'b1;
      end
   end

endmodule

// File: rtl/gcd_requester.sv
// Requester front-end for a GCD controller/datapath pair: accepts operand
// pairs, launches jobs, holds results. Optional timeout: GCD_TIMEOUT_EN.
module gcd_requester
   import gcd_pkg::*;
#(
   parameter int WIDTH   = GCD_WIDTH,
   parameter int TIMEOUT = 255
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   output logic             go,
   output logic [WIDTH-1:0] a_out,
   output logic [WIDTH-1:0] b_out,
   input  logic             done,
   input  logic             output_en,
   input  logic [WIDTH-1:0] gcd_in,
   output logic             res_valid,
   input  logic             res_ready,
   output logic [WIDTH-1:0] res_gcd,
   output logic             res_err,
   output logic             busy
);

   state_e           state_q;
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   logic [WIDTH-1:0] gcd_q;
   logic             go_q;
   logic             vld_q;
   logic             busy_q;
   logic             tmo;
   logic             zero_op;

   assign in_ready  = (state_q == S_IDLE);
   assign go        = go_q;
   assign a_out     = a_q;
   assign b_out     = b_q;
   assign res_valid = vld_q;
   assign res_gcd   = gcd_q;
   assign busy      = busy_q;
   assign zero_op   = (in_a == '0) || (in_b == '0);

`ifdef GCD_TIMEOUT_EN
   logic err_q;
   logic tmr_clr;
   logic tmr_en;

   assign res_err = err_q;
   assign tmr_clr = in_ready && in_valid && !zero_op;
   assign tmr_en  = (state_q == S_WAIT_ACK) || (state_q == S_WAIT_DONE);

   gcd_req_timer #(
      .TIMEOUT (TIMEOUT)
   ) u_timer (
      .clk       (clk),
      .rst       (rst),
      .clr_i     (tmr_clr),
      .en_i      (tmr_en),
      .expired_o (tmo)
   );
`else
   logic unused_tmo;

   assign res_err    = 1'b0;
   assign tmo        = 1'b0;
   assign unused_tmo = (TIMEOUT == 0);
`endif

   // Job sequencing FSM with registered go/result/busy outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         a_q     <= '0;
         b_q     <= '0;
         gcd_q   <= '0;
         go_q    <= 1'b0;
         vld_q   <= 1'b0;
         busy_q  <= 1'b0;
`ifdef GCD_TIMEOUT_EN
         err_q   <= 1'b0;
`endif
      end else begin
         go_q <= 1'b0;
         unique case (state_q)
            S_IDLE: begin
               if (in_valid) begin
                  a_q    <= in_a;
                  b_q    <= in_b;
                  busy_q <= 1'b1;
                  if (zero_op) begin
                     gcd_q   <= in_a | in_b;
                     vld_q   <= 1'b1;
`ifdef GCD_TIMEOUT_EN
                     err_q   <= 1'b0;
`endif
                     state_q <= S_HOLD;
                  end else begin
                     go_q    <= 1'b1;
                     state_q <= S_START;
                  end
               end
            end
            S_START: begin
               state_q <= S_WAIT_ACK;
            end
            S_WAIT_ACK: begin
               if (tmo) begin
                  gcd_q   <= '0;
                  vld_q   <= 1'b1;
`ifdef GCD_TIMEOUT_EN
                  err_q   <= 1'b1;
`endif
                  state_q <= S_HOLD;
               end else if (!done) begin
                  state_q <= S_WAIT_DONE;
               end
            end
            S_WAIT_DONE: begin
               if (done && output_en) begin
                  gcd_q   <= gcd_in;
                  vld_q   <= 1'b1;
`ifdef GCD_TIMEOUT_EN
                  err_q   <= 1'b0;
`endif
                  state_q <= S_HOLD;
               end else if (tmo) begin
                  gcd_q   <= '0;
                  vld_q   <= 1'b1;
`ifdef GCD_TIMEOUT_EN
                  err_q   <= 1'b1;
`endif
                  state_q <= S_HOLD;
               end
            end
            S_HOLD: begin
               if (res_ready) begin
                  vld_q   <= 1'b0;
                  busy_q  <= 1'b0;
                  state_q <= S_IDLE;
               end
            end
            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

endmodule
